// File: rtl/ifetch_line_buffer.sv
// Instruction fetch line buffer: current line plus one prefetched line, aligned issue groups.
// Define IFETCH_PERF_EN to add the saturating perf_* counter ports.
module ifetch_line_buffer #(
  parameter int INSTR_W    = 32,
  parameter int ISSUE_W    = 2,
  parameter int LINE_WORDS = 16,
  parameter int PC_W       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [PC_W-$clog2(LINE_WORDS)-1:0] req_line,
  input  logic                             resp_valid,
  input  logic [LINE_WORDS*INSTR_W-1:0]    resp_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ISSUE_W*INSTR_W-1:0]       out_instr,
  output logic [ISSUE_W-1:0]               out_slot_valid,
  output logic [PC_W-1:0]                  out_pc,
  input  logic                             redirect_valid,
  input  logic [PC_W-1:0]                  redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]                      perf_groups,
  output logic [31:0]                      perf_redirects,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  localparam int LW = $clog2(LINE_WORDS);
  localparam int TW = PC_W - LW;
  localparam int GW = ISSUE_W * INSTR_W;
  localparam int LB = LINE_WORDS * INSTR_W;
  localparam logic [PC_W-1:0] SMASK = PC_W'(ISSUE_W - 1);

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    RUN
  } state_t;

  state_t          state, n_state;
  logic [PC_W-1:0] pc, n_pc;
  logic [LB-1:0]   cur, n_cur;
  logic [TW-1:0]   cur_tag, n_cur_tag;
  logic [LB-1:0]   pf, n_pf;
  logic [TW-1:0]   pf_tag, n_pf_tag;
  logic            pf_valid, n_pf_valid;
  logic            pend, n_pend;
  logic [TW-1:0]   pend_tag, n_pend_tag;
  logic            discard, n_disc;

  logic [PC_W-1:0] grp_next;
  logic [TW-1:0]   tgt;

  logic                n_req_valid;
  logic [TW-1:0]       n_req_line;
  logic [LB-1:0]       shifted;
  logic [GW-1:0]       n_instr;
  logic [ISSUE_W-1:0]  n_slot;
  logic [PC_W-1:0]     n_opc;
  logic [PC_W-1:0]     sub;
  int                  gi;

  // Response, then request handshake, then redirect/consume, each seeing the previous step.
  always_comb begin
    n_state    = state;
    n_pc       = pc;
    n_cur      = cur;
    n_cur_tag  = cur_tag;
    n_pf       = pf;
    n_pf_tag   = pf_tag;
    n_pf_valid = pf_valid;
    n_pend     = pend;
    n_pend_tag = pend_tag;
    n_disc     = discard;
    grp_next   = (pc & ~SMASK) + PC_W'(ISSUE_W);
    tgt        = redirect_pc[PC_W-1:LW];

    if (resp_valid && pend) begin
      n_pend = 1'b0;
      if (discard) begin
        n_disc  = 1'b0;
        n_state = EMPTY;
      end else if (state == WAIT) begin
        n_cur     = resp_data;
        n_cur_tag = pend_tag;
        n_state   = RUN;
      end else begin
        n_pf       = resp_data;
        n_pf_tag   = pend_tag;
        n_pf_valid = 1'b1;
      end
    end

    if (req_valid && req_ready) begin
      n_pend     = 1'b1;
      n_pend_tag = req_line;
      if (state == EMPTY) n_state = WAIT;
    end

    if (redirect_valid) begin
      n_pc = redirect_pc;
      if (!(n_state == RUN && tgt == n_cur_tag)) begin
        if (n_pf_valid && tgt == n_pf_tag) begin
          n_cur      = n_pf;
          n_cur_tag  = n_pf_tag;
          n_pf_valid = 1'b0;
          n_state    = RUN;
        end else begin
          n_pf_valid = 1'b0;
          if (n_pend) begin
            n_disc  = 1'b1;
            n_state = WAIT;
          end else begin
            n_state = EMPTY;
          end
        end
      end
    end else if (out_valid && out_ready) begin
      n_pc = grp_next;
      if (grp_next[PC_W-1:LW] != cur_tag) begin
        if (n_pf_valid) begin
          n_cur      = n_pf;
          n_cur_tag  = n_pf_tag;
          n_pf_valid = 1'b0;
        end else if (n_pend) begin
          n_state = WAIT;
          if (n_pend_tag != grp_next[PC_W-1:LW]) n_disc = 1'b1;
        end else begin
          n_state = EMPTY;
        end
      end
    end
  end

  always_comb begin
    n_req_valid = !n_pend &&
                  (n_state == EMPTY ||
                   (n_state == RUN && !n_pf_valid));
    n_req_line = (n_state == EMPTY) ? n_pc[PC_W-1:LW]
                                    : n_cur_tag + TW'(1);
    gi      = int'(n_pc[LW-1:0]) / ISSUE_W;
    shifted = n_cur << (gi * GW);
    n_instr = shifted[LB-1 -: GW];
    sub     = n_pc & SMASK;
    n_opc   = n_pc & ~SMASK;
    for (int i = 0; i < ISSUE_W; i++) begin
      n_slot[i] = (n_state == RUN) && (PC_W'(i) >= sub);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= EMPTY;
      pc             <= '0;
      cur            <= '0;
      cur_tag        <= '0;
      pf             <= '0;
      pf_tag         <= '0;
      pf_valid       <= 1'b0;
      pend           <= 1'b0;
      pend_tag       <= '0;
      discard        <= 1'b0;
      req_valid      <= 1'b0;
      req_line       <= '0;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_slot_valid <= '0;
      out_pc         <= '0;
    end else begin
      state          <= n_state;
      pc             <= n_pc;
      cur            <= n_cur;
      cur_tag        <= n_cur_tag;
      pf             <= n_pf;
      pf_tag         <= n_pf_tag;
      pf_valid       <= n_pf_valid;
      pend           <= n_pend;
      pend_tag       <= n_pend_tag;
      discard        <= n_disc;
      req_valid      <= n_req_valid;
      req_line       <= n_req_line;
      out_valid      <= (n_state == RUN);
      out_instr      <= n_instr;
      out_slot_valid <= n_slot;
      out_pc         <= n_opc;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_groups       <= '0;
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (out_valid && out_ready && perf_groups != '1)
        perf_groups <= perf_groups + 32'd1;
      if (redirect_valid && perf_redirects != '1)
        perf_redirects <= perf_redirects + 32'd1;
      if (!out_valid && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed bench for ifetch_line_buffer: default instance plus a PC_W=8 wrap instance.
// Line L word i holds 0x1000+16*L+i, so every instruction equals 0x1000+pc.
module tb_ifetch_line_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic         reset_a, req_valid_a, req_ready_a;
  logic [11:0]  req_line_a;
  logic         resp_valid_a;
  logic [511:0] resp_data_a;
  logic         out_valid_a, out_ready_a;
  logic [63:0]  out_instr_a;
  logic [1:0]   slot_a;
  logic [15:0]  out_pc_a;
  logic         redir_a;
  logic [15:0]  redir_pc_a;

  logic         reset_b, req_valid_b, req_ready_b;
  logic [3:0]   req_line_b;
  logic         resp_valid_b;
  logic [511:0] resp_data_b;
  logic         out_valid_b, out_ready_b;
  logic [63:0]  out_instr_b;
  logic [1:0]   slot_b;
  logic [7:0]   out_pc_b;
  logic         redir_b;
  logic [7:0]   redir_pc_b;

  ifetch_line_buffer dut_a (
    .clk(clk), .reset(reset_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_line(req_line_a),
    .resp_valid(resp_valid_a), .resp_data(resp_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_instr(out_instr_a), .out_slot_valid(slot_a),
    .out_pc(out_pc_a),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a)
  );

  ifetch_line_buffer #(.PC_W(8)) dut_b (
    .clk(clk), .reset(reset_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_line(req_line_b),
    .resp_valid(resp_valid_b), .resp_data(resp_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_instr(out_instr_b), .out_slot_valid(slot_b),
    .out_pc(out_pc_b),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b)
  );

  function automatic logic [511:0] line_data(int line);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 16; i++)
      d = (d << 32) | 512'(32'h1000 + line * 16 + i);
    return d;
  endfunction

  function automatic logic [63:0] grp(int pc);
    logic [31:0] w0, w1;
    w0 = 32'h1000 + pc;
    w1 = 32'h1000 + pc + 1;
    return {w0, w1};
  endfunction

  // Local store models: one outstanding line, answered from the second cycle on.
  logic        pend_a = 0, hold_a = 0, spur_a = 0;
  int          age_a = 0;
  logic [11:0] pline_a = '0, last_a = '0;
  always @(posedge clk) begin
    if (req_valid_a && req_ready_a) begin
      pend_a <= 1; age_a <= 0;
      pline_a <= req_line_a; last_a <= req_line_a;
    end else if (resp_valid_a) pend_a <= 0;
    else if (pend_a) age_a <= age_a + 1;
  end
  assign resp_valid_a = (pend_a && age_a >= 1 && !hold_a) || spur_a;
  assign resp_data_a  = line_data(int'(pline_a));

  logic       pend_b = 0;
  int         age_b = 0;
  logic [3:0] pline_b = '0, last_b = '0;
  always @(posedge clk) begin
    if (req_valid_b && req_ready_b) begin
      pend_b <= 1; age_b <= 0;
      pline_b <= req_line_b; last_b <= req_line_b;
    end else if (resp_valid_b) pend_b <= 0;
    else if (pend_b) age_b <= age_b + 1;
  end
  assign resp_valid_b = pend_b && age_b >= 1;
  assign resp_data_b  = line_data(int'(pline_b));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_a(output int w);
    w = 0;
    while (!out_valid_a && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("wait_a_ov", out_valid_a, 1);
  endtask

  task automatic wait_b();
    int w;
    w = 0;
    while (!out_valid_b && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("wait_b_ov", out_valid_b, 1);
  endtask

  task automatic chk_grp_a(string tag, int pc, logic [1:0] sv);
    chk({tag, "_pc"}, out_pc_a, 64'(pc));
    chk({tag, "_sv"}, slot_a, sv);
    if (sv == 2'b11) chk({tag, "_instr"}, out_instr_a, grp(pc));
    else chk({tag, "_slot1"}, out_instr_a[31:0], 64'(32'h1000 + pc + 1));
  endtask

  task automatic redirect_a(logic [15:0] target);
    redir_a = 1; redir_pc_a = target;
    @(negedge clk);
    redir_a = 0;
  endtask

  initial begin
    int w;
    reset_a = 1; reset_b = 1;
    req_ready_a = 0; out_ready_a = 1; redir_a = 0; redir_pc_a = '0;
    req_ready_b = 1; out_ready_b = 0; redir_b = 0; redir_pc_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ov", out_valid_a, 0);
    chk("rst_rv", req_valid_a, 0);
    chk("rst_pc", out_pc_a, 0);
    chk("rst_sv", slot_a, 0);
    chk("rst_instr", out_instr_a, 0);

    reset_a = 0;
    @(negedge clk);
    spur_a = 1;
    @(negedge clk);
    spur_a = 0;
    repeat (2) @(negedge clk);
    chk("spur_ov", out_valid_a, 0);
    chk("req_v0", req_valid_a, 1);
    chk("req_line0", req_line_a, 0);
    req_ready_a = 1;

    for (int k = 0; k < 16; k++) begin
      wait_a(w);
      if (k > 0) chk("nogap", 64'(w), 0);
      chk_grp_a("seq", 2 * k, 2'b11);
      if (k == 3) begin
        out_ready_a = 0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_ov", out_valid_a, 1);
          chk_grp_a("stall", 6, 2'b11);
        end
        out_ready_a = 1;
      end
      @(negedge clk);
    end
    out_ready_a = 0;
    chk("x32_ov", out_valid_a, 1);
    chk_grp_a("x32", 32, 2'b11);
    repeat (8) @(negedge clk);

    redirect_a(16'd200);
    chk("r200_rv", req_valid_a, 1);
    chk("r200_line", req_line_a, 12);
    chk("r200_ov", out_valid_a, 0);
    wait_a(w);
    chk_grp_a("r200", 200, 2'b11);
    repeat (8) @(negedge clk);

    redirect_a(16'd37);
    chk("r37_rv", req_valid_a, 1);
    chk("r37_line", req_line_a, 2);
    wait_a(w);
    chk_grp_a("r37", 36, 2'b10);
    repeat (8) @(negedge clk);

    redirect_a(16'd41);
    chk("r41_ov", out_valid_a, 1);
    chk_grp_a("r41", 40, 2'b10);

    hold_a = 1;
    redirect_a(16'd50);
    chk("r50_ov", out_valid_a, 1);
    chk_grp_a("r50", 50, 2'b11);
    repeat (4) @(negedge clk);

    redirect_a(16'd100);
    chk("r100_ov", out_valid_a, 0);
    chk("r100_rv", req_valid_a, 0);
    redirect_a(16'd120);
    chk("r120_ov0", out_valid_a, 0);
    hold_a = 0;
    wait_a(w);
    chk_grp_a("r120", 120, 2'b11);
    chk("disc_line", last_a, 7);
    out_ready_a = 1;
    @(negedge clk);
    chk_grp_a("seq122", 122, 2'b11);

    @(negedge clk);
    reset_a = 1;
    #1;
    chk("mid_rst_ov", out_valid_a, 0);
    chk("mid_rst_rv", req_valid_a, 0);
    chk("mid_rst_pc", out_pc_a, 0);
    chk("mid_rst_sv", slot_a, 0);
    req_ready_a = 0;
    @(negedge clk);
    reset_a = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_ov", out_valid_a, 0);
    req_ready_a = 1;
    wait_a(w);
    chk_grp_a("post_rst", 0, 2'b11);

    reset_b = 0;
    wait_b();
    chk("b0_pc", out_pc_b, 0);
    chk("b0_instr", out_instr_b, grp(0));
    repeat (8) @(negedge clk);
    redir_b = 1; redir_pc_b = 8'd254;
    @(negedge clk);
    redir_b = 0;
    chk("b254_rline", req_line_b, 15);
    wait_b();
    chk("b254_pc", out_pc_b, 254);
    chk("b254_sv", slot_b, 2'b11);
    chk("b254_instr", out_instr_b, grp(254));
    repeat (8) @(negedge clk);
    chk("bwrap_line", last_b, 0);
    out_ready_b = 1;
    @(negedge clk);
    chk("bwrap_ov", out_valid_b, 1);
    chk("bwrap_pc", out_pc_b, 0);
    chk("bwrap_instr", out_instr_b, grp(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
